// File: rtl/riscv_pkg.sv
// Shared RISC-V memory-system types: memory access sizes, memory-type bit indices,
// PMA arbiter FSM states and the captured checker response.
package riscv_pkg;

    // Access size encodings (if_size_i / dm_size_i / chk_size_o)
    localparam logic [2:0] BYTE  = 3'b000;
    localparam logic [2:0] HWORD = 3'b001;
    localparam logic [2:0] WORD  = 3'b010;
    localparam logic [2:0] DWORD = 3'b011;

    // Memory-type bit positions inside rsp_type_o = {tcm, ext, cache}
    localparam int MEM_TYPE_CACHE = 0;
    localparam int MEM_TYPE_EXT   = 1;
    localparam int MEM_TYPE_TCM   = 2;

    typedef enum logic [1:0] {
        PMA_IDLE  = 2'd0,
        PMA_CHECK = 2'd1,
        PMA_RESP  = 2'd2
    } pma_arb_state_t;

    typedef struct packed {
        logic        exception;
        logic        misaligned;
        logic [2:0]  mem_type;
        logic [13:0] pma;
    } pma_rsp_t;

endpackage

// File: rtl/riscv_pma_arb.sv
// Arbitrates instruction-fetch and data-memory requests onto one shared PMA checker.
// Optional macro RISCV_PMA_ARB_ROUND_ROBIN_EN selects round-robin contention; default is data-first.
module riscv_pma_arb
    import riscv_pkg::*;
#(
    parameter int PLEN = 64
) (
    input  logic            clk_i,
    input  logic            rst_ni,

    input  logic            if_req_i,
    input  logic [PLEN-1:0] if_adr_i,
    input  logic [2:0]      if_size_i,
    input  logic            if_misaligned_i,

    input  logic            dm_req_i,
    input  logic [PLEN-1:0] dm_adr_i,
    input  logic [2:0]      dm_size_i,
    input  logic            dm_we_i,
    input  logic            dm_lock_i,
    input  logic            dm_misaligned_i,

    output logic            if_gnt_o,
    output logic            dm_gnt_o,
    output logic            if_rsp_vld_o,
    output logic            dm_rsp_vld_o,

    output logic            rsp_exception_o,
    output logic            rsp_misaligned_o,
    output logic [2:0]      rsp_type_o,
    output logic [13:0]     rsp_pma_o,

    output logic            chk_req_o,
    output logic            chk_instruction_o,
    output logic [PLEN-1:0] chk_adr_o,
    output logic [2:0]      chk_size_o,
    output logic            chk_we_o,
    output logic            chk_lock_o,
    output logic            chk_misaligned_o,

    input  logic            chk_exception_i,
    input  logic            chk_misaligned_i,
    input  logic            chk_cache_i,
    input  logic            chk_ext_i,
    input  logic            chk_tcm_i,
    input  logic [13:0]     chk_pma_i,

    input  logic            flush_i
);

    pma_arb_state_t r_state, w_state_nxt;

    logic            w_any_req;
    logic            w_grant;
    logic            w_sel_dm;

    logic            r_hold_instr;
    logic [PLEN-1:0] r_hold_adr;
    logic [2:0]      r_hold_size;
    logic            r_hold_we;
    logic            r_hold_lock;
    logic            r_hold_mis;

    pma_rsp_t        r_rsp, w_rsp_nxt;
    logic            r_rsp_dm;

    assign w_any_req = if_req_i | dm_req_i;

    // Grants are combinational and gated by reset so nothing leaks out while rst_ni is low
    assign w_grant = rst_ni & ~flush_i & w_any_req &
                     ((r_state == PMA_IDLE) | (r_state == PMA_RESP));

`ifdef RISCV_PMA_ARB_ROUND_ROBIN_EN
    // r_rr_ptr names the requester favoured on contention (1 = data), i.e. the
    // complement of the last winner; reset favours data.
    logic r_rr_ptr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_rr_ptr <= 1'b1;
        else if (w_grant)
            r_rr_ptr <= ~w_sel_dm;
    end

    assign w_sel_dm = dm_req_i & (~if_req_i | r_rr_ptr);
`else
    assign w_sel_dm = dm_req_i;
`endif

    assign if_gnt_o = w_grant & ~w_sel_dm;
    assign dm_gnt_o = w_grant &  w_sel_dm;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_state <= PMA_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            PMA_IDLE:  if (w_grant) w_state_nxt = PMA_CHECK;
            PMA_CHECK: w_state_nxt = flush_i ? PMA_IDLE : PMA_RESP;
            PMA_RESP:  w_state_nxt = w_grant ? PMA_CHECK : PMA_IDLE;
            default:   w_state_nxt = PMA_IDLE;
        endcase
    end

    // Winner fields are frozen at grant; later requester changes are ignored
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hold_instr <= 1'b0;
            r_hold_adr   <= '0;
            r_hold_size  <= '0;
            r_hold_we    <= 1'b0;
            r_hold_lock  <= 1'b0;
            r_hold_mis   <= 1'b0;
        end else if (w_grant) begin
            r_hold_instr <= ~w_sel_dm;
            r_hold_adr   <= w_sel_dm ? dm_adr_i        : if_adr_i;
            r_hold_size  <= w_sel_dm ? dm_size_i       : if_size_i;
            r_hold_we    <= w_sel_dm & dm_we_i;
            r_hold_lock  <= w_sel_dm & dm_lock_i;
            r_hold_mis   <= w_sel_dm ? dm_misaligned_i : if_misaligned_i;
        end
    end

    always_comb begin
        w_rsp_nxt            = '0;
        w_rsp_nxt.exception  = chk_exception_i;
        w_rsp_nxt.misaligned = chk_misaligned_i;
        w_rsp_nxt.pma        = chk_pma_i;
        if (!(chk_exception_i | chk_misaligned_i)) begin
            w_rsp_nxt.mem_type[MEM_TYPE_TCM]   = chk_tcm_i;
            w_rsp_nxt.mem_type[MEM_TYPE_EXT]   = chk_ext_i;
            w_rsp_nxt.mem_type[MEM_TYPE_CACHE] = chk_cache_i;
        end
    end

    // A flushed check is never captured, so RESP only ever presents completed checks
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rsp    <= '0;
            r_rsp_dm <= 1'b0;
        end else if ((r_state == PMA_CHECK) && !flush_i) begin
            r_rsp    <= w_rsp_nxt;
            r_rsp_dm <= ~r_hold_instr;
        end
    end

    assign chk_req_o         = (r_state == PMA_CHECK);
    assign chk_instruction_o = r_hold_instr;
    assign chk_adr_o         = r_hold_adr;
    assign chk_size_o        = r_hold_size;
    assign chk_we_o          = r_hold_we;
    assign chk_lock_o        = r_hold_lock;
    assign chk_misaligned_o  = r_hold_mis;

    assign if_rsp_vld_o      = (r_state == PMA_RESP) & ~r_rsp_dm;
    assign dm_rsp_vld_o      = (r_state == PMA_RESP) &  r_rsp_dm;

    assign rsp_exception_o   = r_rsp.exception;
    assign rsp_misaligned_o  = r_rsp.misaligned;
    assign rsp_type_o        = r_rsp.mem_type;
    assign rsp_pma_o         = r_rsp.pma;

endmodule

// File: tb/tb_riscv_pma_arb.sv
// Self-checking bench for riscv_pma_arb: scenario tasks with inline checks plus a
// response scoreboard filled at grant time and drained by a response monitor.
module tb_riscv_pma_arb;
    import riscv_pkg::*;

    localparam int PLEN = 64;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            if_req_i = 1'b0, if_misaligned_i = 1'b0;
    logic [PLEN-1:0] if_adr_i = '0;
    logic [2:0]      if_size_i = '0;
    logic            dm_req_i = 1'b0, dm_we_i = 1'b0, dm_lock_i = 1'b0, dm_misaligned_i = 1'b0;
    logic [PLEN-1:0] dm_adr_i = '0;
    logic [2:0]      dm_size_i = '0;
    logic            if_gnt_o, dm_gnt_o, if_rsp_vld_o, dm_rsp_vld_o;
    logic            rsp_exception_o, rsp_misaligned_o;
    logic [2:0]      rsp_type_o;
    logic [13:0]     rsp_pma_o;
    logic            chk_req_o, chk_instruction_o, chk_we_o, chk_lock_o, chk_misaligned_o;
    logic [PLEN-1:0] chk_adr_o;
    logic [2:0]      chk_size_o;
    logic            chk_exception_i = 1'b0, chk_misaligned_i = 1'b0;
    logic            chk_cache_i = 1'b0, chk_ext_i = 1'b0, chk_tcm_i = 1'b0;
    logic [13:0]     chk_pma_i = '0;
    logic            flush_i = 1'b0;

    always #5 clk_i = ~clk_i;

    riscv_pma_arb #(.PLEN(PLEN)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .if_req_i(if_req_i), .if_adr_i(if_adr_i), .if_size_i(if_size_i),
        .if_misaligned_i(if_misaligned_i),
        .dm_req_i(dm_req_i), .dm_adr_i(dm_adr_i), .dm_size_i(dm_size_i), .dm_we_i(dm_we_i),
        .dm_lock_i(dm_lock_i), .dm_misaligned_i(dm_misaligned_i),
        .if_gnt_o(if_gnt_o), .dm_gnt_o(dm_gnt_o),
        .if_rsp_vld_o(if_rsp_vld_o), .dm_rsp_vld_o(dm_rsp_vld_o),
        .rsp_exception_o(rsp_exception_o), .rsp_misaligned_o(rsp_misaligned_o),
        .rsp_type_o(rsp_type_o), .rsp_pma_o(rsp_pma_o),
        .chk_req_o(chk_req_o), .chk_instruction_o(chk_instruction_o), .chk_adr_o(chk_adr_o),
        .chk_size_o(chk_size_o), .chk_we_o(chk_we_o), .chk_lock_o(chk_lock_o),
        .chk_misaligned_o(chk_misaligned_o),
        .chk_exception_i(chk_exception_i), .chk_misaligned_i(chk_misaligned_i),
        .chk_cache_i(chk_cache_i), .chk_ext_i(chk_ext_i), .chk_tcm_i(chk_tcm_i),
        .chk_pma_i(chk_pma_i),
        .flush_i(flush_i)
    );

    typedef struct packed {
        logic        dm;
        logic        exc;
        logic        mis;
        logic [2:0]  typ;
        logic [13:0] pma;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e, mon_g;
    int   n_cmp = 0;
    int   n_err = 0;

    // Expected response for a grant, given the checker inputs the bench will hold during CHECK
    function automatic exp_t mk_exp(input logic dm);
        exp_t e;
        e.dm  = dm;
        e.exc = chk_exception_i;
        e.mis = chk_misaligned_i;
        e.typ = (chk_exception_i | chk_misaligned_i) ? 3'b000 : {chk_tcm_i, chk_ext_i, chk_cache_i};
        e.pma = chk_pma_i;
        return e;
    endfunction

    always @(negedge clk_i) begin
        #2;
        if (if_rsp_vld_o || dm_rsp_vld_o) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_rsp: if_vld=%0b dm_vld=%0b, want no response", if_rsp_vld_o, dm_rsp_vld_o);
            end else begin
                mon_e = sb_q.pop_front();
                mon_g = {dm_rsp_vld_o, rsp_exception_o, rsp_misaligned_o, rsp_type_o, rsp_pma_o};
                if (mon_g !== mon_e || (if_rsp_vld_o && dm_rsp_vld_o)) begin
                    n_err++;
                    $display("FAIL rsp_scoreboard: got %h (if_vld=%0b) want %h", mon_g, if_rsp_vld_o, mon_e);
                end
            end
        end
    end

    task automatic test_reset();
        rst_ni = 1'b0; if_req_i = 1'b1; dm_req_i = 1'b1; if_adr_i = '1;
        repeat (2) @(negedge clk_i);
        #1;
        n_cmp++; if ({if_gnt_o, dm_gnt_o} !== 2'b00) begin n_err++; $display("FAIL reset_gnt: got %b want 00", {if_gnt_o, dm_gnt_o}); end
        n_cmp++; if (chk_req_o !== 1'b0) begin n_err++; $display("FAIL reset_chk_req: got %b want 0", chk_req_o); end
        n_cmp++; if ({if_rsp_vld_o, dm_rsp_vld_o} !== 2'b00) begin n_err++; $display("FAIL reset_vld: got %b want 00", {if_rsp_vld_o, dm_rsp_vld_o}); end
        n_cmp++; if (chk_adr_o !== '0) begin n_err++; $display("FAIL reset_hold_adr: got %h want 0", chk_adr_o); end
        n_cmp++; if ({rsp_exception_o, rsp_misaligned_o, rsp_type_o, rsp_pma_o} !== 19'd0) begin
            n_err++; $display("FAIL reset_rsp: got %h want 0", {rsp_exception_o, rsp_misaligned_o, rsp_type_o, rsp_pma_o}); end
        @(negedge clk_i);
        if_req_i = 1'b0; dm_req_i = 1'b0; if_adr_i = '0; rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_single_fetch();
        chk_cache_i = 1'b1; chk_pma_i = 14'h0011;
        if_req_i = 1'b1; if_adr_i = 64'h1000; if_size_i = WORD;
        #1;
        n_cmp++; if ({if_gnt_o, dm_gnt_o} !== 2'b10) begin n_err++; $display("FAIL fetch_gnt: got %b want 10", {if_gnt_o, dm_gnt_o}); end
        if (if_gnt_o) sb_q.push_back(mk_exp(1'b0));
        @(negedge clk_i); if_req_i = 1'b0; if_adr_i = 64'hdead; #1;
        n_cmp++; if ({chk_req_o, chk_instruction_o, chk_we_o, chk_lock_o} !== 4'b1100) begin
            n_err++; $display("FAIL fetch_chk_ctl: got %b want 1100", {chk_req_o, chk_instruction_o, chk_we_o, chk_lock_o}); end
        n_cmp++; if (chk_adr_o !== 64'h1000 || chk_size_o !== WORD) begin
            n_err++; $display("FAIL fetch_chk_fields: got %h/%0d want 1000/%0d", chk_adr_o, chk_size_o, WORD); end
        @(negedge clk_i); #1;
        n_cmp++; if ({if_rsp_vld_o, rsp_type_o} !== 4'b1001) begin
            n_err++; $display("FAIL fetch_rsp: got vld=%b type=%b want vld=1 type=001", if_rsp_vld_o, rsp_type_o); end
        @(negedge clk_i); #1;
        n_cmp++; if ({if_rsp_vld_o, chk_req_o} !== 2'b00) begin n_err++; $display("FAIL fetch_idle: got %b want 00", {if_rsp_vld_o, chk_req_o}); end
        chk_cache_i = 1'b0; chk_pma_i = '0;
    endtask

    task automatic test_contention();
        logic [3:0] exp_order;
        int cnt;
`ifdef RISCV_PMA_ARB_ROUND_ROBIN_EN
        exp_order = 4'b0101;  // bit i = 1 when grant i goes to data: dm, if, dm, if
`else
        exp_order = 4'b1111;
`endif
        cnt = 0;
        chk_ext_i = 1'b1; chk_pma_i = 14'h0155;
        @(negedge clk_i);
        if_req_i = 1'b1; if_adr_i = 64'h5000; dm_req_i = 1'b1; dm_adr_i = 64'h4000;
        for (int c = 0; c < 20 && cnt < 4; c++) begin
            if (c != 0) @(negedge clk_i);
            #1;
            if (if_gnt_o || dm_gnt_o) begin
                n_cmp++; if (dm_gnt_o !== exp_order[cnt] || if_gnt_o === dm_gnt_o) begin
                    n_err++; $display("FAIL contention_order[%0d]: got dm_gnt=%b if_gnt=%b want dm_gnt=%b", cnt, dm_gnt_o, if_gnt_o, exp_order[cnt]); end
                sb_q.push_back(mk_exp(dm_gnt_o));
                cnt++;
            end
        end
        n_cmp++; if (cnt != 4) begin n_err++; $display("FAIL contention_count: got %0d want 4", cnt); end
        @(negedge clk_i); if_req_i = 1'b0; dm_req_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk_ext_i = 1'b0; chk_pma_i = '0;
    endtask

    task automatic test_flush();
        flush_i = 1'b1; dm_req_i = 1'b1; dm_adr_i = 64'h2000; #1;
        n_cmp++; if (dm_gnt_o !== 1'b0) begin n_err++; $display("FAIL flush_idle_gnt: got %b want 0", dm_gnt_o); end
        @(negedge clk_i); flush_i = 1'b0; #1;
        n_cmp++; if (dm_gnt_o !== 1'b1) begin n_err++; $display("FAIL flush_dm_gnt: got %b want 1", dm_gnt_o); end
        @(negedge clk_i); dm_req_i = 1'b0; flush_i = 1'b1; if_req_i = 1'b1; if_adr_i = 64'h6000; chk_tcm_i = 1'b1; #1;
        n_cmp++; if ({chk_req_o, if_gnt_o} !== 2'b10) begin n_err++; $display("FAIL flush_check_cycle: got %b want 10", {chk_req_o, if_gnt_o}); end
        @(negedge clk_i); flush_i = 1'b0; #1;
        n_cmp++; if ({dm_rsp_vld_o, chk_req_o} !== 2'b00) begin n_err++; $display("FAIL flush_suppress: got %b want 00", {dm_rsp_vld_o, chk_req_o}); end
        n_cmp++; if (if_gnt_o !== 1'b1) begin n_err++; $display("FAIL flush_regrant: got %b want 1", if_gnt_o); end
        if (if_gnt_o) sb_q.push_back(mk_exp(1'b0));
        @(negedge clk_i); if_req_i = 1'b0; #1;
        n_cmp++; if (chk_adr_o !== 64'h6000) begin n_err++; $display("FAIL flush_regrant_adr: got %h want 6000", chk_adr_o); end
        repeat (2) @(negedge clk_i);
        chk_tcm_i = 1'b0;
    endtask

    task automatic test_exception();
        chk_exception_i = 1'b1; chk_ext_i = 1'b1; chk_pma_i = 14'h2A5;
        dm_req_i = 1'b1; dm_adr_i = 64'h7000; #1;
        if (dm_gnt_o) sb_q.push_back(mk_exp(1'b1));
        @(negedge clk_i); dm_req_i = 1'b0;
        @(negedge clk_i); #1;
        n_cmp++; if ({dm_rsp_vld_o, rsp_exception_o, rsp_type_o} !== 5'b11000) begin
            n_err++; $display("FAIL exc_rsp: got vld=%b exc=%b type=%b want 1/1/000", dm_rsp_vld_o, rsp_exception_o, rsp_type_o); end
        @(negedge clk_i);
        chk_exception_i = 1'b0; chk_misaligned_i = 1'b1; chk_tcm_i = 1'b1;
        dm_req_i = 1'b1; dm_adr_i = 64'h7003; dm_size_i = WORD; dm_we_i = 1'b1; dm_lock_i = 1'b1; dm_misaligned_i = 1'b1; #1;
        if (dm_gnt_o) sb_q.push_back(mk_exp(1'b1));
        @(negedge clk_i); dm_req_i = 1'b0; dm_we_i = 1'b0; dm_lock_i = 1'b0; dm_misaligned_i = 1'b0; #1;
        n_cmp++; if ({chk_instruction_o, chk_we_o, chk_lock_o, chk_misaligned_o} !== 4'b0111) begin
            n_err++; $display("FAIL mis_chk_fields: got %b want 0111", {chk_instruction_o, chk_we_o, chk_lock_o, chk_misaligned_o}); end
        @(negedge clk_i); #1;
        n_cmp++; if ({dm_rsp_vld_o, rsp_misaligned_o, rsp_type_o} !== 5'b11000) begin
            n_err++; $display("FAIL mis_rsp: got vld=%b mis=%b type=%b want 1/1/000", dm_rsp_vld_o, rsp_misaligned_o, rsp_type_o); end
        @(negedge clk_i);
        chk_misaligned_i = 1'b0; chk_tcm_i = 1'b0; chk_ext_i = 1'b0; chk_pma_i = '0;
    endtask

    task automatic test_reset_midop();
        int bad;
        bad = 0;
        dm_req_i = 1'b1; dm_adr_i = 64'h8000; #1;
        n_cmp++; if (dm_gnt_o !== 1'b1) begin n_err++; $display("FAIL rstmid_gnt: got %b want 1", dm_gnt_o); end
        @(negedge clk_i); rst_ni = 1'b0; #1;
        n_cmp++; if ({chk_req_o, dm_gnt_o, if_gnt_o, dm_rsp_vld_o} !== 4'b0000 || chk_adr_o !== '0) begin
            n_err++; $display("FAIL rstmid_outputs: got ctl=%b adr=%h want 0000/0", {chk_req_o, dm_gnt_o, if_gnt_o, dm_rsp_vld_o}, chk_adr_o); end
        @(negedge clk_i); dm_req_i = 1'b0; rst_ni = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1; if (dm_rsp_vld_o || if_rsp_vld_o || chk_req_o) bad++;
            @(negedge clk_i);
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL rstmid_no_rsp: got %0d active cycles want 0", bad); end
    endtask

    task automatic test_back_to_back();
        logic [PLEN-1:0] lat_adr;
        int gcyc[$];
        logic just;
        just = 1'b0; lat_adr = '0;
        chk_cache_i = 1'b1; chk_pma_i = 14'h0ABC;
        dm_req_i = 1'b1; dm_adr_i = 64'h3000; dm_size_i = DWORD;
        for (int c = 0; c < 30 && gcyc.size() < 4; c++) begin
            if (c != 0) @(negedge clk_i);
            if (just) begin dm_adr_i = dm_adr_i + 64'h40 + 64'($urandom_range(0, 7) * 8); just = 1'b0; end
            #1;
            if (chk_req_o) begin
                n_cmp++; if (chk_adr_o !== lat_adr) begin n_err++; $display("FAIL b2b_chk_adr: got %h want %h", chk_adr_o, lat_adr); end
            end
            if (dm_gnt_o) begin
                gcyc.push_back(c); lat_adr = dm_adr_i; sb_q.push_back(mk_exp(1'b1)); just = 1'b1;
            end
        end
        @(negedge clk_i); dm_req_i = 1'b0; dm_adr_i = '1; #1;
        n_cmp++; if (chk_req_o !== 1'b1 || chk_adr_o !== lat_adr) begin
            n_err++; $display("FAIL b2b_last_adr: got req=%b adr=%h want 1/%h", chk_req_o, chk_adr_o, lat_adr); end
        n_cmp++; if (gcyc.size() != 4) begin n_err++; $display("FAIL b2b_grants: got %0d want 4", gcyc.size()); end
        for (int i = 1; i < gcyc.size(); i++) begin
            n_cmp++; if (gcyc[i] - gcyc[i-1] != 2) begin
                n_err++; $display("FAIL b2b_spacing[%0d]: got %0d want 2", i, gcyc[i] - gcyc[i-1]); end
        end
        repeat (2) @(negedge clk_i);
        chk_cache_i = 1'b0; chk_pma_i = '0;
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_contention();
        test_flush();
        test_exception();
        test_reset_midop();
        test_back_to_back();
        for (int c = 0; c < 10 && sb_q.size() != 0; c++) @(negedge clk_i);
        repeat (2) @(negedge clk_i);
        n_cmp++; if (sb_q.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
